// File: rtl/fifo_arb_ctrl_if.sv
// Bundle of requester handshakes, pop/control strobes, memory port and status
// signals for the two-requester FIFO controller.
interface fifo_arb_ctrl_if #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 32
);
  logic                req0_valid;
  logic [DATA_LEN-1:0] req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [DATA_LEN-1:0] req1_data;
  logic                req1_ready;
  logic                rd_en;
  logic                flush;
  logic                clr_err;
  logic                mem_wen;
  logic [ADDR_LEN-1:0] mem_waddr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [ADDR_LEN-1:0] mem_raddr;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic [ADDR_LEN:0]   count;
  logic                underflow;

  // Controller side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rd_en, flush, clr_err,
    output req0_ready, req1_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr,
           full, empty, almost_full, count, underflow
  );

  // Requester / consumer side.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rd_en, flush, clr_err,
    input  req0_ready, req1_ready, mem_wen, mem_waddr, mem_wdata, mem_raddr,
           full, empty, almost_full, count, underflow
  );
endinterface

// File: rtl/fifo_arb_ctrl.sv
// FIFO pointer/status controller with a two-requester round-robin write arbiter.
// The storage array is external: writes go out on mem_w*, the head word is read
// combinationally at mem_raddr.
module fifo_arb_ctrl #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 32,
  parameter int AF_LEVEL = (1 << ADDR_LEN) - 4
) (
  input logic          clk,
  input logic          rst,
  fifo_arb_ctrl_if.slave bus
);
  localparam logic [ADDR_LEN:0] AF_CNT = (ADDR_LEN+1)'(AF_LEVEL);
  localparam logic [ADDR_LEN:0] PTR_ONE = (ADDR_LEN+1)'(1);

  logic [ADDR_LEN:0] wptr;
  logic [ADDR_LEN:0] rptr;
  logic              prio;
  logic              underflow_q;

  logic              grant0;
  logic              grant1;
  logic              fire0;
  logic              fire1;
  logic              wr_fire;
  logic              rd_fire;
  logic              full_int;
  logic              empty_int;
  logic [ADDR_LEN:0] count_int;

  // Occupancy and status derived purely from the current pointers.
  always_comb begin
    count_int = wptr - rptr;
    empty_int = (wptr == rptr);
    full_int  = (wptr[ADDR_LEN] != rptr[ADDR_LEN]) &&
                (wptr[ADDR_LEN-1:0] == rptr[ADDR_LEN-1:0]);
  end

  // Arbitration, handshakes and fire qualification; prio only breaks ties.
  always_comb begin
    grant0  = bus.req0_valid && (!bus.req1_valid || !prio);
    grant1  = bus.req1_valid && (!bus.req0_valid || prio);
    bus.req0_ready = grant0 && !full_int && !bus.flush && !rst;
    bus.req1_ready = grant1 && !full_int && !bus.flush && !rst;
    fire0   = bus.req0_valid && bus.req0_ready;
    fire1   = bus.req1_valid && bus.req1_ready;
    wr_fire = fire0 || fire1;
    rd_fire = bus.rd_en && !empty_int && !bus.flush;
  end

  // Output drive for the memory port and status.
  always_comb begin
    bus.mem_wen     = wr_fire;
    bus.mem_wdata   = fire1 ? bus.req1_data : bus.req0_data;
    bus.mem_waddr   = wptr[ADDR_LEN-1:0];
    bus.mem_raddr   = rptr[ADDR_LEN-1:0];
    bus.count       = count_int;
    bus.empty       = empty_int;
    bus.full        = full_int;
    bus.almost_full = (count_int >= AF_CNT);
    bus.underflow   = underflow_q;
  end

  // Pointer and priority state; flush restarts the queue at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      prio <= 1'b0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
      prio <= 1'b0;
    end else begin
      if (wr_fire) begin
        wptr <= wptr + PTR_ONE;
        prio <= fire0;
      end
      if (rd_fire) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Sticky underflow: a new pop-while-empty beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_q <= 1'b0;
    end else if (bus.rd_en && empty_int && !bus.flush) begin
      underflow_q <= 1'b1;
    end else if (bus.clr_err) begin
      underflow_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl with a behavioural memory on the mem port.
module tb_fifo_arb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_arb_ctrl_if #(.ADDR_LEN(8), .DATA_LEN(32)) bus ();

  fifo_arb_ctrl #(.ADDR_LEN(8), .DATA_LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] rd_data;

  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
  end
  assign rd_data = mem[bus.mem_raddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rd_en      = 1'b0;
    bus.flush      = 1'b0;
    bus.clr_err    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.req0_data = '0;
    bus.req1_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset: handshakes and write enable held low while rst is high
    bus.req0_valid = 1'b1;
    tick();
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_wen", bus.mem_wen, 0);
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_waddr", bus.mem_waddr, 0);
    chk("rst_raddr", bus.mem_raddr, 0);
    chk("rst_underflow", bus.underflow, 0);

    // fill with requester 0 only
    for (int i = 0; i < 256; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'(i);
      #1;
      chk("fill_ready", bus.req0_ready, 1);
      chk("fill_waddr", bus.mem_waddr, 64'(i));
      chk("fill_af", bus.almost_full, (i >= 252) ? 1 : 0);
      tick();
    end
    #1;
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 256);
    chk("fill_af_end", bus.almost_full, 1);
    chk("fill_ready257", bus.req0_ready, 0);

    // full with simultaneous read and write: only the read happens
    bus.rd_en = 1'b1;
    bus.req0_data = 32'hAAAA;
    #1;
    chk("fullrw_ready", bus.req0_ready, 0);
    chk("fullrw_wen", bus.mem_wen, 0);
    chk("fullrw_head", rd_data, 0);
    tick();
    bus.rd_en = 1'b0;
    #1;
    chk("fullrw_count", bus.count, 255);
    chk("fullrw_notfull", bus.full, 0);
    chk("fullrw_ready_next", bus.req0_ready, 1);
    chk("fullrw_waddr", bus.mem_waddr, 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("refill_full", bus.full, 1);

    // drain everything in order
    for (int j = 0; j < 256; j++) begin
      bus.rd_en = 1'b1;
      #1;
      chk("drain_data", rd_data, (j < 255) ? 64'(j + 1) : 64'hAAAA);
      tick();
    end
    bus.rd_en = 1'b0;
    #1;
    chk("drain_empty", bus.empty, 1);

    // underflow: pop while empty
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    #1;
    chk("uf_set", bus.underflow, 1);
    chk("uf_count", bus.count, 0);
    chk("uf_raddr", bus.mem_raddr, 1);
    bus.rd_en = 1'b1;
    bus.clr_err = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    #1;
    chk("uf_set_wins", bus.underflow, 1);
    tick();
    bus.clr_err = 1'b0;
    #1;
    chk("uf_clear", bus.underflow, 0);

    // flush at count 10 with underflow set
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.req1_valid = 1'b1;
      bus.req1_data  = 32'(32'h300 + i);
      #1;
      chk("solo1_ready", bus.req1_ready, 1);
      tick();
    end
    bus.req1_valid = 1'b0;
    #1;
    chk("flush_pre_count", bus.count, 10);
    chk("flush_pre_uf", bus.underflow, 1);
    bus.flush = 1'b1;
    bus.req0_valid = 1'b1;
    bus.rd_en = 1'b1;
    #1;
    chk("flush_ready", bus.req0_ready, 0);
    chk("flush_wen", bus.mem_wen, 0);
    tick();
    idle();
    #1;
    chk("flush_empty", bus.empty, 1);
    chk("flush_count", bus.count, 0);
    chk("flush_waddr", bus.mem_waddr, 0);
    chk("flush_uf_held", bus.underflow, 1);

    // contention: alternating grants starting with requester 0
    for (int k = 0; k < 4; k++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data  = 32'(32'h100 + k);
      bus.req1_data  = 32'(32'h200 + k);
      #1;
      chk("cont_ready0", bus.req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("cont_ready1", bus.req1_ready, (k % 2 == 1) ? 1 : 0);
      chk("cont_waddr", bus.mem_waddr, 64'(k));
      chk("cont_wdata", bus.mem_wdata, (k % 2 == 0) ? 64'(32'h100 + k) : 64'(32'h200 + k));
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rd_en = 1'b1;
    #1;
    chk("cont_rd0", rd_data, 64'h100);
    tick();
    chk("cont_rd1", rd_data, 64'h201);
    tick();
    chk("cont_rd2", rd_data, 64'h102);
    tick();
    chk("cont_rd3", rd_data, 64'h203);
    tick();
    bus.rd_en = 1'b0;
    #1;
    chk("cont_empty", bus.empty, 1);

    // reset mid-burst
    for (int i = 0; i < 5; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'(32'h400 + i);
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_ready", bus.req0_ready, 0);
    tick();
    rst = 1'b0;
    bus.req0_data = 32'h4FF;
    #1;
    chk("midrst_waddr", bus.mem_waddr, 0);
    chk("midrst_ready_after", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("midrst_count1", bus.count, 1);
    chk("midrst_head", rd_data, 64'h4FF);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // wrap: 300 writes interleaved with 300 reads
    for (int i = 0; i < 300; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'(32'h5000 + i);
      bus.rd_en      = (i > 0);
      #1;
      if (i > 0) begin
        chk("wrap_data", rd_data, 64'(32'h5000 + i - 1));
        chk("wrap_count", bus.count, 1);
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.rd_en = 1'b1;
    #1;
    chk("wrap_last", rd_data, 64'(32'h5000 + 299));
    tick();
    bus.rd_en = 1'b0;
    #1;
    chk("wrap_empty", bus.empty, 1);
    chk("wrap_count_end", bus.count, 0);
    chk("wrap_waddr", bus.mem_waddr, 44);
    chk("wrap_raddr", bus.mem_raddr, 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
